// File: rtl/tracer_pkg.sv
// Shared types for the PC watchpoint tracer: capture FSM states, trace
// entries and per-channel watchpoint configuration.
package tracer_pkg;

    localparam int MAX_ID_W    = 4;
    localparam int MAX_DELAY_W = 16;
    localparam logic [MAX_DELAY_W-1:0] DLY_ONE = 16'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [31:0]         pc;
        logic [31:0]         data;
    } trace_entry_t;

    typedef struct packed {
        logic                   en;
        logic [31:0]            addr;
        logic [4:0]             reg_idx;
        logic [MAX_DELAY_W-1:0] delay;
    } watch_cfg_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'd0, inc};
        if (sum[8]) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace entries; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module trace_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t din_i,
    output entry_t dout_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t               mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q, count_d;
    logic                 do_push_s, do_pop_s;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Accepted push/pop and the resulting occupancy
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - (PTR_W+1)'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage; contents are masked by empty_o so they need no reset
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/pc_watch_tracer.sv
// Watches the processor PC against programmable watchpoints and, after a
// per-channel delay, samples a snooped register into a trace FIFO.
module pc_watch_tracer
    import tracer_pkg::*;
#(
    parameter int          NUM_WATCH  = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DELAY_W    = 4,
    parameter logic [31:0] HALT_ADDR  = 32'h0,
    localparam int         IDX_W      = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr_addr,
    output logic [4:0]         reg_sel,
    input  logic [31:0]        reg_data,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_en,
    input  logic [31:0]        cfg_addr,
    input  logic [4:0]         cfg_reg,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [IDX_W-1:0]   trace_id,
    output logic [31:0]        trace_pc,
    output logic [31:0]        trace_data,
    output logic               halted,
    output logic [7:0]         drop_cnt
);

    watch_cfg_t              cfg_q [NUM_WATCH];
    cap_state_e              state_q, state_d;
    logic [IDX_W-1:0]        cap_id_q, cap_id_d;
    logic [31:0]             cap_pc_q, cap_pc_d;
    logic [4:0]              cap_reg_q, cap_reg_d, reg_sel_q, reg_sel_d;
    logic [MAX_DELAY_W-1:0]  cnt_q, cnt_d;
    logic [7:0]              drop_q, drop_d;
    logic                    halted_q, halted_d;
    logic [31:0]             prev_pc_q;
    logic                    prev_valid_q;
    logic                    hit_s, qual_s, push_s, pop_s, lost_hit_s, push_drop_s;
    logic                    fifo_full_s, fifo_empty_s;
    logic [IDX_W-1:0]        hit_idx_s;
    trace_entry_t            push_entry_s, head_s;

    // Watchpoint configuration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WATCH; i++) cfg_q[i] <= '0;
        end else if (cfg_we && (32'(cfg_idx) < 32'(NUM_WATCH))) begin
            cfg_q[cfg_idx] <= '{en: cfg_en, addr: cfg_addr, reg_idx: cfg_reg,
                                delay: MAX_DELAY_W'(cfg_delay)};
        end
    end

    // Lowest-index matching channel; a PC only counts once per change
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = NUM_WATCH - 1; i >= 0; i--) begin
            if (cfg_q[i].en && (cfg_q[i].addr == instr_addr)) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
        qual_s = hit_s && !halted_q && (!prev_valid_q || (instr_addr != prev_pc_q));
    end

    // Capture FSM next state, FIFO push and drop accounting
    always_comb begin
        state_d    = state_q;
        cap_id_d   = cap_id_q;
        cap_pc_d   = cap_pc_q;
        cap_reg_d  = cap_reg_q;
        cnt_d      = cnt_q;
        push_s     = 1'b0;
        lost_hit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (qual_s) begin
                    cap_id_d  = hit_idx_s;
                    cap_pc_d  = instr_addr;
                    cap_reg_d = cfg_q[hit_idx_s].reg_idx;
                    cnt_d     = cfg_q[hit_idx_s].delay;
                    state_d   = (cfg_q[hit_idx_s].delay != '0) ? WAIT : SAMPLE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                lost_hit_s = qual_s;
                if (cnt_q <= DLY_ONE) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - DLY_ONE;
                end
            end
            SAMPLE: begin
                lost_hit_s = qual_s;
                push_s     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        reg_sel_d    = (state_d != IDLE) ? cap_reg_d : 5'd0;
        pop_s        = !fifo_empty_s && trace_ready;
        push_drop_s  = push_s && fifo_full_s && !pop_s;
        push_entry_s = '{id: MAX_ID_W'(cap_id_q), pc: cap_pc_q, data: reg_data};
        drop_d       = sat_add8(drop_q, {1'b0, lost_hit_s} + {1'b0, push_drop_s});
        halted_d     = halted_q | (instr_addr == HALT_ADDR);
    end

    // Capture and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cap_id_q     <= '0;
            cap_pc_q     <= 32'd0;
            cap_reg_q    <= 5'd0;
            cnt_q        <= '0;
            reg_sel_q    <= 5'd0;
            drop_q       <= 8'd0;
            halted_q     <= 1'b0;
            prev_pc_q    <= 32'd0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_id_q     <= cap_id_d;
            cap_pc_q     <= cap_pc_d;
            cap_reg_q    <= cap_reg_d;
            cnt_q        <= cnt_d;
            reg_sel_q    <= reg_sel_d;
            drop_q       <= drop_d;
            halted_q     <= halted_d;
            prev_pc_q    <= instr_addr;
            prev_valid_q <= 1'b1;
        end
    end

    trace_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (trace_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (push_entry_s),
        .dout_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign reg_sel     = reg_sel_q;
    assign trace_valid = !fifo_empty_s;
    assign trace_id    = head_s.id[IDX_W-1:0];
    assign trace_pc    = head_s.pc;
    assign trace_data  = head_s.data;
    assign halted      = halted_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_pc_watch_tracer.sv
// Self-checking bench for pc_watch_tracer: a cycle-timestamp reference model
// checked every cycle, plus a vector table and directed corner sequences.
module tb_pc_watch_tracer;

    localparam logic [31:0] IDLE_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_addr;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        cfg_we, cfg_en;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [4:0]  cfg_reg;
    logic [3:0]  cfg_delay;
    logic        trace_valid, trace_ready;
    logic [1:0]  trace_id;
    logic [31:0] trace_pc, trace_data;
    logic        halted;
    logic [7:0]  drop_cnt;
    logic [31:0] rf [32];

    assign reg_data = rf[reg_sel];
    always #5 clk = ~clk;

    pc_watch_tracer dut (
        .clk(clk), .reset(reset), .instr_addr(instr_addr), .reg_sel(reg_sel),
        .reg_data(reg_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_addr(cfg_addr), .cfg_reg(cfg_reg), .cfg_delay(cfg_delay),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_id(trace_id),
        .trace_pc(trace_pc), .trace_data(trace_data), .halted(halted), .drop_cnt(drop_cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: a capture is a pending sample scheduled for an absolute cycle
    typedef struct { int id; logic [31:0] pc; logic [31:0] data; } ent_t;
    ent_t        m_q[$];
    bit          m_en [4];
    logic [31:0] m_addr [4];
    int          m_rsel [4];
    int          m_dly [4];
    bit          m_pending, m_halted, m_prev_valid;
    int          m_sample_at, m_id, m_reg, m_drops, cyc;
    logic [31:0] m_pc, m_prev_pc;

    typedef struct {
        logic [31:0] pc; logic ready; logic [31:0] r2;
        logic valid; logic [1:0] id; logic [31:0] tpc; logic [31:0] tdata; logic [4:0] rsel;
    } vec_t;
    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 1'b0; m_addr[i] = 32'h0; m_rsel[i] = 0; m_dly[i] = 0;
        end
        m_pending = 1'b0; m_halted = 1'b0; m_prev_valid = 1'b0;
        m_drops = 0; m_prev_pc = 32'h0;
    endtask

    task automatic model_cycle();
        bit qual, pop, sampled;
        int hit_ch, nd;
        ent_t e;
        qual = !m_halted && (!m_prev_valid || instr_addr != m_prev_pc);
        hit_ch = -1;
        for (int i = 0; i < 4; i++)
            if (hit_ch < 0 && m_en[i] && m_addr[i] == instr_addr) hit_ch = i;
        pop = trace_ready && (m_q.size() > 0);
        sampled = m_pending && (cyc == m_sample_at);
        if (sampled) e = '{m_id, m_pc, rf[m_reg]};
        nd = 0;
        if (qual && hit_ch >= 0) begin
            if (m_pending) nd++;
            else begin
                m_pending = 1'b1; m_id = hit_ch; m_pc = instr_addr;
                m_reg = m_rsel[hit_ch]; m_sample_at = cyc + 1 + m_dly[hit_ch];
            end
        end
        if (sampled) m_pending = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (sampled) begin
            if (m_q.size() < 8) m_q.push_back(e);
            else nd++;
        end
        m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
        if (instr_addr == 32'h0) m_halted = 1'b1;
        if (cfg_we) begin
            m_en[cfg_idx] = cfg_en; m_addr[cfg_idx] = cfg_addr;
            m_rsel[cfg_idx] = int'(cfg_reg); m_dly[cfg_idx] = int'(cfg_delay);
        end
        m_prev_pc = instr_addr; m_prev_valid = 1'b1;
        cyc++;
    endtask

    task automatic check_model();
        string tag;
        logic [31:0] e_id, e_pc, e_data;
        tag = $sformatf("cyc%0d", cyc);
        e_id = 32'h0; e_pc = 32'h0; e_data = 32'h0;
        if (m_q.size() > 0) begin
            e_id = 32'(m_q[0].id); e_pc = m_q[0].pc; e_data = m_q[0].data;
        end
        chk({tag, ".valid"},   32'(trace_valid), 32'(m_q.size() > 0));
        chk({tag, ".id"},      32'(trace_id), e_id);
        chk({tag, ".pc"},      trace_pc, e_pc);
        chk({tag, ".data"},    trace_data, e_data);
        chk({tag, ".reg_sel"}, 32'(reg_sel), m_pending ? 32'(m_reg) : 32'h0);
        chk({tag, ".halted"},  32'(halted), 32'(m_halted));
        chk({tag, ".drop"},    32'(drop_cnt), 32'(m_drops));
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},   32'(trace_valid), 32'h0);
        chk({tag, ".id"},      32'(trace_id), 32'h0);
        chk({tag, ".pc"},      trace_pc, 32'h0);
        chk({tag, ".data"},    trace_data, 32'h0);
        chk({tag, ".reg_sel"}, 32'(reg_sel), 32'h0);
        chk({tag, ".halted"},  32'(halted), 32'h0);
        chk({tag, ".drop"},    32'(drop_cnt), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk_zero({tag, ".async"});
        repeat (2) @(posedge clk);
        #1;
        chk_zero({tag, ".held"});
        reset = 1'b1;
        model_reset();
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] a, input int r, input int d);
        cfg_we = 1'b1; cfg_idx = 2'(ch); cfg_addr = a;
        cfg_reg = 5'(r); cfg_delay = 4'(d); cfg_en = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic hit_then_idle(input logic [31:0] a, input int idle_ticks);
        instr_addr = a;
        tick();
        instr_addr = IDLE_PC;
        repeat (idle_ticks) tick();
    endtask

    logic [31:0] pool [6];
    logic [31:0] drain_exp [8];

    initial begin
        vt[0]  = '{32'h8002_0020, 1'b0, 32'd11, 1'b0, 2'd0, 32'h0,          32'd0,  5'd4};
        vt[1]  = '{32'h8002_0024, 1'b0, 32'd11, 1'b1, 2'd0, 32'h8002_0020,  32'd5,  5'd0};
        vt[2]  = '{32'h8002_0028, 1'b1, 32'd11, 1'b0, 2'd0, 32'h0,          32'd0,  5'd0};
        vt[3]  = '{32'h8002_0064, 1'b0, 32'd11, 1'b0, 2'd0, 32'h0,          32'd0,  5'd2};
        vt[4]  = '{32'h8002_0068, 1'b0, 32'd11, 1'b0, 2'd0, 32'h0,          32'd0,  5'd2};
        vt[5]  = '{32'h8002_006C, 1'b0, 32'd11, 1'b0, 2'd0, 32'h0,          32'd0,  5'd2};
        vt[6]  = '{32'h8002_0070, 1'b0, 32'd22, 1'b0, 2'd0, 32'h0,          32'd0,  5'd2};
        vt[7]  = '{32'h8002_0074, 1'b0, 32'd22, 1'b0, 2'd0, 32'h0,          32'd0,  5'd2};
        vt[8]  = '{32'h8002_0078, 1'b0, 32'd22, 1'b0, 2'd0, 32'h0,          32'd0,  5'd2};
        vt[9]  = '{32'h8002_007C, 1'b0, 32'd22, 1'b1, 2'd1, 32'h8002_0064,  32'd22, 5'd0};
        vt[10] = '{32'h8002_0080, 1'b1, 32'd22, 1'b0, 2'd0, 32'h0,          32'd0,  5'd0};
        pool = '{32'h8002_0020, 32'h8002_0064, 32'h8002_0184, 32'h8003_0000,
                 32'h8004_0000, 32'h8004_0004};
        drain_exp = '{32'd101, 32'd102, 32'd103, 32'd104, 32'd105, 32'd106, 32'd107, 32'd200};

        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
        reset = 1'b0; instr_addr = IDLE_PC; trace_ready = 1'b0;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_en = 1'b0; cfg_addr = 32'h0;
        cfg_reg = 5'd0; cfg_delay = 4'd0; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("por");
        reset = 1'b1;
        model_reset();
        tick();

        // Delay-0 and delay-5 captures from the vector table
        rf[4] = 32'd5;
        cfg_write(0, 32'h8002_0020, 4, 0);
        cfg_write(1, 32'h8002_0064, 2, 5);
        for (int i = 0; i < 11; i++) begin
            instr_addr = vt[i].pc; trace_ready = vt[i].ready; rf[2] = vt[i].r2;
            tick();
            chk($sformatf("vec%0d.valid", i),   32'(trace_valid), 32'(vt[i].valid));
            chk($sformatf("vec%0d.id", i),      32'(trace_id), 32'(vt[i].id));
            chk($sformatf("vec%0d.pc", i),      trace_pc, vt[i].tpc);
            chk($sformatf("vec%0d.data", i),    trace_data, vt[i].tdata);
            chk($sformatf("vec%0d.reg_sel", i), 32'(reg_sel), 32'(vt[i].rsel));
        end
        trace_ready = 1'b0; instr_addr = IDLE_PC;

        // Two channels on one PC: lowest index wins, nothing dropped
        rf[7] = 32'h77;
        cfg_write(0, 32'h8002_0184, 7, 0);
        cfg_write(2, 32'h8002_0184, 7, 0);
        hit_then_idle(32'h8002_0184, 1);
        chk("simul.valid", 32'(trace_valid), 32'h1);
        chk("simul.id",    32'(trace_id), 32'h0);
        chk("simul.data",  trace_data, 32'h77);
        chk("simul.drop",  32'(drop_cnt), 32'h0);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        chk("simul.empty", 32'(trace_valid), 32'h0);

        // Nine captures into an 8-deep FIFO, then push while full with a pop
        cfg_write(3, 32'h8003_0000, 9, 1);
        for (int k = 0; k < 9; k++) begin
            rf[9] = 32'(100 + k);
            hit_then_idle(32'h8003_0000, 3);
        end
        chk("full.drop", 32'(drop_cnt), 32'h1);
        chk("full.head", trace_data, 32'd100);
        rf[9] = 32'd200;
        hit_then_idle(32'h8003_0000, 1);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0; tick();
        chk("fullpop.drop", 32'(drop_cnt), 32'h1);
        trace_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d.data", j), trace_data, drain_exp[j]);
            tick();
        end
        trace_ready = 1'b0;
        chk("drain.empty", 32'(trace_valid), 32'h0);

        // Hit during WAIT is dropped; halt stops new hits but not in-flight ones
        rf[9] = 32'h99;
        cfg_write(3, 32'h8007_0000, 9, 4);
        hit_then_idle(32'h8007_0000, 1);
        hit_then_idle(32'h8007_0000, 4);
        chk("busy.drop",  32'(drop_cnt), 32'h2);
        chk("busy.data",  trace_data, 32'h99);
        chk("busy.id",    32'(trace_id), 32'h3);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        chk("pre_halt", 32'(halted), 32'h0);
        rf[9] = 32'hAB;
        instr_addr = 32'h8007_0000; tick();
        instr_addr = 32'h0; tick();
        chk("halt.set", 32'(halted), 32'h1);
        instr_addr = IDLE_PC;
        repeat (5) tick();
        chk("halt.inflight", trace_data, 32'hAB);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        hit_then_idle(32'h8007_0000, 6);
        chk("halt.ignored", 32'(trace_valid), 32'h0);
        chk("halt.drop",    32'(drop_cnt), 32'h2);

        // Reset clears halt; then reset in the middle of a delayed capture
        do_reset("rst_halt");
        tick();
        rf[3] = 32'h33;
        cfg_write(0, 32'h8005_0000, 3, 0);
        cfg_write(1, 32'h8005_0010, 3, 4);
        hit_then_idle(32'h8005_0000, 1);
        hit_then_idle(32'h8005_0010, 2);
        do_reset("rst_wait");
        repeat (10) tick();
        chk("rst.noentry", 32'(trace_valid), 32'h0);
        hit_then_idle(32'h8005_0000, 1);
        chk("rst.cfgclr", 32'(trace_valid), 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                cfg_we = 1'b1; cfg_idx = 2'($urandom_range(0, 3));
                cfg_en = 1'($urandom_range(0, 3) != 0);
                cfg_addr = pool[$urandom_range(0, 5)];
                cfg_reg = 5'($urandom_range(0, 31)); cfg_delay = 4'($urandom_range(0, 15));
            end else begin
                cfg_we = 1'b0;
            end
            if ($urandom_range(0, 2) != 0) instr_addr = pool[$urandom_range(0, 5)];
            trace_ready = 1'($urandom_range(0, 1));
            rf[$urandom_range(0, 31)] = $urandom();
            tick();
        end
        cfg_we = 1'b0; instr_addr = IDLE_PC; trace_ready = 1'b1;
        repeat (20) tick();
        trace_ready = 1'b0;

        // Drop counter saturation
        cfg_write(0, 32'h8006_0000, 1, 0);
        for (int n = 0; n < 300; n++) hit_then_idle(32'h8006_0000, 1);
        chk("sat.drop",  32'(drop_cnt), 32'd255);
        chk("sat.valid", 32'(trace_valid), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
